// File: rtl/fc_io_pkg.sv
// fc_io_pkg
// Shared types and helpers for the fc_* layer host stream master.
//   fc_io_state_t : frame sequencing states (idle, send vector, receive results, done pulse)
//   addr_w(n)     : index width for an n-entry buffer, never narrower than one bit
package fc_io_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } fc_io_state_t;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_io_regfile.sv
// fc_io_regfile
// Small register-file buffer with one write port and one synchronous read port.
// Ports:
//   clk      : clock, all logic on posedge
//   reset    : synchronous active-high, clears only the read data register
//   wr_en    : write wr_data into entry wr_addr
//   wr_addr  : write index
//   wr_data  : write data
//   rd_en    : load rd_data from entry rd_addr at the next edge, otherwise hold
//   rd_addr  : read index
//   rd_data  : registered read data (one cycle latency)
module fc_io_regfile
    import fc_io_pkg::*;
#(
    parameter int DEPTH = 6,
    parameter int T     = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [addr_w(DEPTH)-1:0] wr_addr,
    input  logic [T-1:0]             wr_data,
    input  logic                     rd_en,
    input  logic [addr_w(DEPTH)-1:0] rd_addr,
    output logic [T-1:0]             rd_data
);

    localparam int AW    = addr_w(DEPTH);
    localparam int SLOTS = 1 << AW;

    // Storage is rounded up to a power of two so every address value maps to
    // a real slot; indices at or above DEPTH are simply never used by the top.
    logic [T-1:0] mem [SLOTS];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register sees the pre-write contents when reading and writing the
    // same entry in one cycle. Holding it when rd_en is low keeps a stalled
    // output stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fc_stream_master.sv
// fc_stream_master
// Host-side transmitter/receiver for one fc_* layer's valid/ready streams.
// The host preloads an N-element vector and pulses start; the block streams the
// vector to the layer, then collects the M results into a readable buffer.
// Ports:
//   clk, reset                 : clock and synchronous active-high reset
//   host_wr_en/addr/data       : vector buffer write (dropped while busy)
//   start                      : begin a frame (ignored while busy)
//   busy                       : frame in progress, through the done cycle
//   done                       : one-cycle pulse once all results are captured
//   host_rd_addr/host_rd_data  : result buffer read, one cycle latency
//   tx_valid/tx_ready/tx_data  : stream into the layer input
//   rx_valid/rx_ready/rx_data  : stream from the layer output
module fc_stream_master
    import fc_io_pkg::*;
#(
    parameter int M = 6,
    parameter int N = 6,
    parameter int T = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 host_wr_en,
    input  logic [addr_w(N)-1:0] host_wr_addr,
    input  logic [T-1:0]         host_wr_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    input  logic [addr_w(M)-1:0] host_rd_addr,
    output logic [T-1:0]         host_rd_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [T-1:0]         tx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    input  logic [T-1:0]         rx_data
);

    localparam int AW_N = addr_w(N);
    localparam int AW_M = addr_w(M);
    localparam logic [AW_N-1:0] TX_LAST = AW_N'(N - 1);
    localparam logic [AW_M-1:0] RX_LAST = AW_M'(M - 1);

    fc_io_state_t    state;
    logic [AW_N-1:0] tx_idx;
    logic [AW_M-1:0] rx_idx;

    logic            vbuf_we;
    logic            vbuf_re;
    logic [AW_N-1:0] vbuf_raddr;
    logic            rbuf_we;

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign rx_ready = (state == RECV);

    assign vbuf_we = host_wr_en && (state == IDLE);
    assign rbuf_we = rx_valid && rx_ready;

    // tx_data is the vector buffer's read register. The first SEND cycle
    // fetches element 0 with tx_valid still low; afterwards each accepted beat
    // fetches the following element so back-to-back beats run at full rate.
    // No fetch on a stall, so tx_data holds.
    assign vbuf_re    = (state == SEND) &&
                        (!tx_valid || (tx_ready && (tx_idx != TX_LAST)));
    assign vbuf_raddr = tx_valid ? (tx_idx + AW_N'(1)) : tx_idx;

    // Frame sequencing. tx_valid, once raised, stays high until the last
    // element is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx_idx   <= '0;
            rx_idx   <= '0;
            tx_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= SEND;
                        tx_idx <= '0;
                    end
                end
                SEND: begin
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                    end else if (tx_ready) begin
                        if (tx_idx == TX_LAST) begin
                            state    <= RECV;
                            rx_idx   <= '0;
                            tx_valid <= 1'b0;
                        end else begin
                            tx_idx <= tx_idx + AW_N'(1);
                        end
                    end
                end
                RECV: begin
                    if (rx_valid && rx_ready) begin
                        rx_idx <= rx_idx + AW_M'(1);
                        if (rx_idx == RX_LAST) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    fc_io_regfile #(
        .DEPTH (N),
        .T     (T)
    ) vbuf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (vbuf_we),
        .wr_addr (host_wr_addr),
        .wr_data (host_wr_data),
        .rd_en   (vbuf_re),
        .rd_addr (vbuf_raddr),
        .rd_data (tx_data)
    );

    fc_io_regfile #(
        .DEPTH (M),
        .T     (T)
    ) rbuf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rbuf_we),
        .wr_addr (rx_idx),
        .wr_data (rx_data),
        .rd_en   (1'b1),
        .rd_addr (host_rd_addr),
        .rd_data (host_rd_data)
    );

endmodule

// File: tb/tb_fc_stream_master.sv
// tb_fc_stream_master
// Bench for fc_stream_master: a 6x6 instance checked every cycle against a
// frame-level model, plus a 1x1 instance checked with literal expectations.
module tb_fc_stream_master;

    localparam int N = 6;
    localparam int M = 6;
    localparam int T = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         host_wr_en;
    logic [2:0]   host_wr_addr;
    logic [T-1:0] host_wr_data;
    logic         start;
    logic         busy;
    logic         done;
    logic [2:0]   host_rd_addr;
    logic [T-1:0] host_rd_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [T-1:0] tx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [T-1:0] rx_data;

    logic         s_wr_en;
    logic [0:0]   s_wr_addr;
    logic [T-1:0] s_wr_data;
    logic         s_start;
    logic         s_busy;
    logic         s_done;
    logic [0:0]   s_rd_addr;
    logic [T-1:0] s_rd_data;
    logic         s_tx_valid;
    logic         s_tx_ready;
    logic [T-1:0] s_tx_data;
    logic         s_rx_valid;
    logic         s_rx_ready;
    logic [T-1:0] s_rx_data;

    fc_stream_master #(.M(M), .N(N), .T(T)) dut (
        .clk          (clk),
        .reset        (reset),
        .host_wr_en   (host_wr_en),
        .host_wr_addr (host_wr_addr),
        .host_wr_data (host_wr_data),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .host_rd_addr (host_rd_addr),
        .host_rd_data (host_rd_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data)
    );

    fc_stream_master #(.M(1), .N(1), .T(T)) dut1 (
        .clk          (clk),
        .reset        (reset),
        .host_wr_en   (s_wr_en),
        .host_wr_addr (s_wr_addr),
        .host_wr_data (s_wr_data),
        .start        (s_start),
        .busy         (s_busy),
        .done         (s_done),
        .host_rd_addr (s_rd_addr),
        .host_rd_data (s_rd_data),
        .tx_valid     (s_tx_valid),
        .tx_ready     (s_tx_ready),
        .tx_data      (s_tx_data),
        .rx_valid     (s_rx_valid),
        .rx_ready     (s_rx_ready),
        .rx_data      (s_rx_data)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    task automatic checkOutput(input string name, input logic signed [31:0] actual,
                               input logic signed [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    always @(posedge clk) cyc++;

    // Stimulus tables and layer-side driver settings.
    int vec[N];
    int rx_vals[M];
    int tx_mode = 0;
    int rx_mode = 0;
    int rx_ptr  = 0;

    // Layer model: tx_ready pattern per mode; results offered in order, with
    // mode 2 showing junk value 99 whenever the master is not accepting.
    always @(posedge clk) begin
        #2;
        case (tx_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            default: tx_ready = 1'b0;
        endcase
        if (rx_mode != 0 && rx_ptr < M) begin
            rx_valid = 1'b1;
            rx_data  = (rx_mode == 2 && rx_ready !== 1'b1) ? T'(99) : T'(rx_vals[rx_ptr]);
        end else begin
            rx_valid = 1'b0;
            rx_data  = '0;
        end
    end

    // Observed traffic for the literal checks.
    logic signed [T-1:0] seq[$];
    int                  done_cnt   = 0;
    int                  s_tx_beats = 0;
    int                  s_rx_beats = 0;
    logic signed [T-1:0] s_tx_last  = '0;

    always @(negedge clk) begin
        if (tx_valid === 1'b1 && tx_ready === 1'b1) seq.push_back(tx_data);
        if (rx_valid === 1'b1 && rx_ready === 1'b1) rx_ptr++;
        if (done === 1'b1) done_cnt++;
        if (s_tx_valid === 1'b1 && s_tx_ready === 1'b1) begin
            s_tx_beats++;
            s_tx_last = s_tx_data;
        end
        if (s_rx_valid === 1'b1 && s_rx_ready === 1'b1) s_rx_beats++;
    end

    // Frame-level model of the 6x6 instance: a frame is "send the snapshot of
    // the vector in order, then take M results in order, then one done cycle".
    logic signed [T-1:0] m_vbuf[N];
    logic signed [T-1:0] frame_vec[N];
    logic signed [T-1:0] m_rbuf[M];
    bit                  m_rvalid[M];
    bit                  m_busy    = 1'b0;
    int                  sent      = 0;
    int                  recv      = 0;
    bit                  txv_seen  = 1'b0;
    bit                  m_exp_rx  = 1'b0;
    logic signed [T-1:0] exp_rd    = '0;
    bit                  exp_rd_ok = 1'b0;

    initial begin
        for (int i = 0; i < N; i++) m_vbuf[i] = '0;
        for (int i = 0; i < M; i++) m_rvalid[i] = 1'b0;
    end

    always @(negedge clk) begin
        m_exp_rx = m_busy && (sent == N) && (recv < M);
        checkOutput("busy", busy, m_busy);
        checkOutput("done", done, m_busy && (recv == M));
        checkOutput("rx_ready", rx_ready, m_exp_rx);
        if (exp_rd_ok) checkOutput("host_rd_data", $signed(host_rd_data), exp_rd);
        if (m_busy && sent < N) begin
            if (tx_valid === 1'b1) checkOutput($sformatf("tx_data[%0d]", sent), $signed(tx_data), frame_vec[sent]);
            else if (txv_seen) checkOutput("tx_valid_held", tx_valid, 1);
        end else begin
            checkOutput("tx_valid_quiet", tx_valid, 0);
        end

        if (reset === 1'b1) begin
            exp_rd    = '0;
            exp_rd_ok = 1'b1;
        end else if (int'(host_rd_addr) < M) begin
            exp_rd    = m_rbuf[host_rd_addr];
            exp_rd_ok = m_rvalid[host_rd_addr];
        end else begin
            exp_rd_ok = 1'b0;
        end

        if (reset === 1'b1) begin
            m_busy   = 1'b0;
            sent     = 0;
            recv     = 0;
            txv_seen = 1'b0;
        end else if (!m_busy) begin
            if (host_wr_en === 1'b1 && int'(host_wr_addr) < N) m_vbuf[host_wr_addr] = host_wr_data;
            if (start === 1'b1) begin
                frame_vec = m_vbuf;
                m_busy    = 1'b1;
                sent      = 0;
                recv      = 0;
                txv_seen  = 1'b0;
            end
        end else if (recv == M) begin
            m_busy = 1'b0;
        end else begin
            if (sent < N && tx_valid === 1'b1) begin
                txv_seen = 1'b1;
                if (tx_ready === 1'b1) sent++;
            end
            if (m_exp_rx && rx_valid === 1'b1) begin
                m_rbuf[recv]   = rx_data;
                m_rvalid[recv] = 1'b1;
                recv++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadVector();
        for (int i = 0; i < N; i++) begin
            host_wr_en   = 1'b1;
            host_wr_addr = 3'(i);
            host_wr_data = T'(vec[i]);
            tick();
        end
        host_wr_en = 1'b0;
    endtask

    task automatic readResult(input int addr, output logic signed [31:0] val);
        host_rd_addr = 3'(addr);
        tick();
        val = $signed(host_rd_data);
    endtask

    // Pulses start, waits (bounded) for done and returns the start-to-done
    // distance in cycles. Returns in the idle cycle following done.
    task automatic applyStimulus(input int txm, input int rxm, output int latency);
        int start_cyc;
        tx_mode  = txm;
        rx_mode  = rxm;
        rx_ptr   = 0;
        done_cnt = 0;
        seq.delete();
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        latency = cyc - start_cyc;
        checkOutput("done_reached", done, 1);
        tick();
    endtask

    task automatic checkSeq(input string tag);
        checkOutput({tag, "_beats"}, seq.size(), N);
        for (int i = 0; i < N; i++)
            checkOutput($sformatf("%s_tx[%0d]", tag, i), (i < seq.size()) ? seq[i] : -9999, vec[i]);
    endtask

    task automatic checkResults(input string tag);
        logic signed [31:0] rv;
        for (int i = 0; i < M; i++) begin
            readResult(i, rv);
            checkOutput($sformatf("%s_rbuf[%0d]", tag, i), rv, rx_vals[i]);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        int start_cyc;
        logic signed [31:0] rv;

        reset        = 1'b1;
        host_wr_en   = 1'b0;
        host_wr_addr = '0;
        host_wr_data = '0;
        start        = 1'b0;
        host_rd_addr = '0;
        tx_ready     = 1'b0;
        rx_valid     = 1'b0;
        rx_data      = '0;
        s_wr_en      = 1'b0;
        s_wr_addr    = '0;
        s_wr_data    = '0;
        s_start      = 1'b0;
        s_rd_addr    = '0;
        s_tx_ready   = 1'b1;
        s_rx_valid   = 1'b0;
        s_rx_data    = '0;

        repeat (3) tick();
        checkOutput("rst_tx_valid", tx_valid, 0);
        checkOutput("rst_rx_ready", rx_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_tx_data", $signed(tx_data), 0);
        checkOutput("rst_host_rd_data", $signed(host_rd_data), 0);
        checkOutput("rst_s_busy", s_busy, 0);
        reset = 1'b0;
        tick();

        $display("[TB] test 1: continuous frame");
        vec     = '{1, 2, 3, 4, 5, 6};
        rx_vals = '{10, -20, 30, -40, 50, -2048};
        loadVector();
        applyStimulus(0, 1, lat);
        checkOutput("t1_latency", lat, 14);
        checkSeq("t1");
        checkResults("t1");
        checkOutput("t1_done_pulses", done_cnt, 1);

        $display("[TB] test 2: tx_ready toggling");
        rx_vals = '{100, 200, 300, 400, 500, 600};
        applyStimulus(1, 1, lat);
        checkSeq("t2");
        checkResults("t2");

        $display("[TB] test 3: rx_valid outside RECV");
        rx_vals = '{7, 8, 9, 10, 11, 12};
        applyStimulus(0, 2, lat);
        checkResults("t3");

        $display("[TB] test 4: start and write while busy");
        rx_vals = '{-1, -2, -3, -4, -5, -6};
        fork
            applyStimulus(0, 1, lat);
            begin
                repeat (3) tick();
                start        = 1'b1;
                host_wr_en   = 1'b1;
                host_wr_addr = 3'd0;
                host_wr_data = T'(77);
                tick();
                start      = 1'b0;
                host_wr_en = 1'b0;
            end
        join
        checkOutput("t4_latency", lat, 14);
        checkOutput("t4_first", (seq.size() > 0) ? seq[0] : -9999, 1);
        applyStimulus(0, 1, lat);
        checkOutput("t4_restart_latency", lat, 14);
        checkOutput("t4_restart_first", (seq.size() > 0) ? seq[0] : -9999, 1);
        checkResults("t4");

        $display("[TB] test 5: reset mid-frame");
        tx_mode  = 0;
        rx_mode  = 1;
        rx_ptr   = 0;
        done_cnt = 0;
        seq.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            #1;
            if (seq.size() >= 3) break;
        end
        checkOutput("t5_three_beats", (seq.size() >= 3) ? 1 : 0, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("t5_tx_valid_after_reset", tx_valid, 0);
        checkOutput("t5_busy_after_reset", busy, 0);
        repeat (20) tick();
        checkOutput("t5_no_done", done_cnt, 0);
        rx_vals = '{21, 22, 23, 24, 25, 26};
        applyStimulus(0, 1, lat);
        checkOutput("t5_latency", lat, 14);
        checkSeq("t5");
        checkResults("t5");

        $display("[TB] test 6: single-element build");
        s_wr_en   = 1'b1;
        s_wr_addr = 1'b0;
        s_wr_data = T'(-2048);
        tick();
        s_wr_en    = 1'b0;
        s_rx_valid = 1'b1;
        s_rx_data  = T'(-2048);
        s_tx_beats = 0;
        s_rx_beats = 0;
        s_start    = 1'b1;
        start_cyc  = cyc;
        tick();
        s_start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (s_done === 1'b1) break;
        end
        checkOutput("t6_done_reached", s_done, 1);
        checkOutput("t6_latency", cyc - start_cyc, 4);
        tick();
        s_rx_valid = 1'b0;
        checkOutput("t6_busy_after", s_busy, 0);
        checkOutput("t6_tx_beats", s_tx_beats, 1);
        checkOutput("t6_rx_beats", s_rx_beats, 1);
        checkOutput("t6_tx_data", s_tx_last, -2048);
        s_rd_addr = 1'b0;
        tick();
        checkOutput("t6_rbuf", $signed(s_rd_data), -2048);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
